// File: rtl/light_mask_compositor.sv
// Per-pixel darkness compositor: circular lights punch holes in a faded dark mask.
// Three pix_en-gated pipeline stages (distance, squared distance, select/scale)
// plus a frame-synchronous fade FSM that ramps the darkness level.
module light_mask_compositor #(
  parameter int unsigned NUM_LIGHTS = 2,
  parameter int unsigned COORD_W    = 9,
  parameter int unsigned R2_W       = 12,
  parameter int unsigned FADE_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_en,
  input  logic [9:0]                     h_cnt,
  input  logic [9:0]                     v_cnt,
  input  logic [11:0]                    pixel_in,
  input  logic                           pixel_valid,
  input  logic                           frame_start,
  input  logic                           dark_en,
  input  logic [COORD_W-1:0]             region_x0,
  input  logic [COORD_W-1:0]             region_y0,
  input  logic [NUM_LIGHTS*COORD_W-1:0]  light_x,
  input  logic [NUM_LIGHTS*COORD_W-1:0]  light_y,
  input  logic [NUM_LIGHTS*R2_W-1:0]     light_r2,
  input  logic [NUM_LIGHTS-1:0]          light_en,
  output logic [11:0]                    rgb_out,
  output logic                           rgb_valid,
  output logic                           lit,
  output logic [FADE_W:0]                fade_level,
  output logic                           fade_busy
);

  localparam int unsigned D2_W  = 2 * COORD_W + 1;
  localparam int unsigned LVL_W = FADE_W + 1;
  localparam logic [LVL_W-1:0] FadeMax = LVL_W'(1 << FADE_W);

  typedef enum logic [1:0] {StLit, StFadeOut, StDark, StFadeIn} fade_state_e;

  fade_state_e      state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             busy_q;

  // Stage registers
  logic [NUM_LIGHTS-1:0][COORD_W-1:0] dx_q, dy_q, dx_c, dy_c;
  logic [NUM_LIGHTS-1:0][D2_W-1:0]    d2_q, d2_c;
  logic        region1_q, region2_q, valid1_q, valid2_q;
  logic [11:0] pix1_q, pix2_q;
  logic [11:0] rgb_q, rgb_d;
  logic        rgb_valid_q, lit_q, lit_d;

  logic [COORD_W-1:0] x_c, y_c;
  logic               region_c;
  logic               unused_cnt;

  // Counter LSBs (and any bits beyond COORD_W) are dropped by the halving.
  assign unused_cnt = ^{h_cnt, v_cnt};

  assign x_c      = COORD_W'(h_cnt >> 1);
  assign y_c      = COORD_W'(v_cnt >> 1);
  assign region_c = (x_c >= region_x0) && (y_c >= region_y0);

  function automatic logic [3:0] scale_ch(input logic [3:0] ch, input logic [LVL_W-1:0] lvl);
    logic [LVL_W+3:0] prod;
    prod     = (LVL_W + 4)'(ch) * (LVL_W + 4)'(lvl);
    scale_ch = 4'(prod >> FADE_W);
  endfunction

  // S1 combinational: per-light absolute coordinate distance
  always_comb begin
    dx_c = '0;
    dy_c = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      logic [COORD_W-1:0] lx, ly;
      lx = light_x[i*COORD_W +: COORD_W];
      ly = light_y[i*COORD_W +: COORD_W];
      dx_c[i] = (x_c >= lx) ? x_c - lx : lx - x_c;
      dy_c[i] = (y_c >= ly) ? y_c - ly : ly - y_c;
    end
  end

  // S2 combinational: squared distance, wide enough never to overflow
  always_comb begin
    d2_c = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      d2_c[i] = D2_W'(dx_q[i]) * D2_W'(dx_q[i]) + D2_W'(dy_q[i]) * D2_W'(dy_q[i]);
    end
  end

  // S3 combinational: strict radius test and output select
  always_comb begin
    lit_d = 1'b0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      if (light_en[i] && (32'(d2_q[i]) < 32'(light_r2[i*R2_W +: R2_W]))) lit_d = 1'b1;
    end
    if (!valid2_q) begin
      rgb_d = '0;
    end else if (!region2_q || lit_d || (level_q == FadeMax)) begin
      rgb_d = pix2_q;
    end else begin
      rgb_d = {scale_ch(pix2_q[11:8], level_q), scale_ch(pix2_q[7:4], level_q),
               scale_ch(pix2_q[3:0], level_q)};
    end
  end

  // Pipeline state, advanced only on pixel strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q        <= '0;
      dy_q        <= '0;
      region1_q   <= 1'b0;
      valid1_q    <= 1'b0;
      pix1_q      <= '0;
      d2_q        <= '0;
      region2_q   <= 1'b0;
      valid2_q    <= 1'b0;
      pix2_q      <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      lit_q       <= 1'b0;
    end else if (pix_en) begin
      dx_q        <= dx_c;
      dy_q        <= dy_c;
      region1_q   <= region_c;
      valid1_q    <= pixel_valid;
      pix1_q      <= pixel_in;
      d2_q        <= d2_c;
      region2_q   <= region1_q;
      valid2_q    <= valid1_q;
      pix2_q      <= pix1_q;
      rgb_q       <= rgb_d;
      rgb_valid_q <= valid2_q;
      lit_q       <= lit_d;
    end
  end

  // Fade next state: direction follows dark_en immediately; a step happens only on
  // frame_start and always uses the current direction, saturating at both ends.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (dark_en) begin
      if (state_q != StDark) begin
        state_d = StFadeOut;
        if (frame_start) begin
          if (level_q <= LVL_W'(1)) begin
            level_d = '0;
            state_d = StDark;
          end else begin
            level_d = level_q - LVL_W'(1);
          end
        end
      end
    end else begin
      if (state_q != StLit) begin
        state_d = StFadeIn;
        if (frame_start) begin
          if (level_q >= FadeMax - LVL_W'(1)) begin
            level_d = FadeMax;
            state_d = StLit;
          end else begin
            level_d = level_q + LVL_W'(1);
          end
        end
      end
    end
  end

  // Fade state, level and registered busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLit;
      level_q <= FadeMax;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      busy_q  <= (state_d == StFadeOut) || (state_d == StFadeIn);
    end
  end

  assign rgb_out    = rgb_q;
  assign rgb_valid  = rgb_valid_q;
  assign lit        = lit_q;
  assign fade_level = level_q;
  assign fade_busy  = busy_q;

endmodule

// File: tb/tb_light_mask_compositor.sv
// Directed bench for light_mask_compositor: pass-through latency, radius edge,
// fade scaling, reversal, region/enable masking and asynchronous reset.
module tb_light_mask_compositor;

  logic        clk, rst, pix_en, pixel_valid, frame_start, dark_en;
  logic [9:0]  h_cnt, v_cnt;
  logic [11:0] pixel_in, rgb_out;
  logic [8:0]  region_x0, region_y0;
  logic [17:0] light_x, light_y;
  logic [23:0] light_r2;
  logic [1:0]  light_en;
  logic        rgb_valid, lit, fade_busy;
  logic [4:0]  fade_level;

  int n_cmp  = 0;
  int n_fail = 0;

  light_mask_compositor dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .dark_en    (dark_en),
    .region_x0  (region_x0),
    .region_y0  (region_y0),
    .light_x    (light_x),
    .light_y    (light_y),
    .light_r2   (light_r2),
    .light_en   (light_en),
    .rgb_out    (rgb_out),
    .rgb_valid  (rgb_valid),
    .lit        (lit),
    .fade_level (fade_level),
    .fade_busy  (fade_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One pixel beat: pix_en high for one clk out of four; ends on a negedge.
  task automatic beat();
    @(negedge clk) pix_en = 1'b1;
    @(negedge clk) pix_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frame_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
    end
  endtask

  // Hold one pixel for the full pipeline depth, then check the result.
  task automatic run_px(input string tag, input logic [9:0] h, input logic [9:0] v,
                        input logic [11:0] pix, input logic [11:0] exp_rgb, input logic exp_lit);
    h_cnt = h;
    v_cnt = v;
    pixel_in = pix;
    pixel_valid = 1'b1;
    beat();
    beat();
    beat();
    check_eq({tag, "_rgb"}, 16'(rgb_out), 16'(exp_rgb));
    check_eq({tag, "_lit"}, 16'(lit), 16'(exp_lit));
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    dark_en = 1'b0;
    h_cnt = '0;
    v_cnt = '0;
    pixel_in = '0;
    region_x0 = '0;
    region_y0 = '0;
    light_x = {9'd200, 9'd100};
    light_y = {9'd200, 9'd100};
    light_r2 = {12'd100, 12'd400};
    light_en = 2'b01;
    #12;
    check_eq("rst_level", 16'(fade_level), 16'd16);
    check_eq("rst_busy", 16'(fade_busy), 16'd0);
    check_eq("rst_valid", 16'(rgb_valid), 16'd0);
    check_eq("rst_rgb", 16'(rgb_out), 16'd0);
    @(negedge clk) rst = 1'b0;

    // Pass-through: three beats of latency, zeros before
    pixel_in = 12'hABC;
    pixel_valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      beat();
      if (b < 3) begin
        check_eq("pt_early_valid", 16'(rgb_valid), 16'd0);
        check_eq("pt_early_rgb", 16'(rgb_out), 16'd0);
      end
    end
    check_eq("pt_valid", 16'(rgb_valid), 16'd1);
    check_eq("pt_rgb", 16'(rgb_out), 16'hABC);
    // Without pix_en the pipeline holds
    pixel_in = 12'h000;
    pixel_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("hold_rgb", 16'(rgb_out), 16'hABC);
    check_eq("hold_valid", 16'(rgb_valid), 16'd1);

    // Fade scaling at level 8
    dark_en = 1'b1;
    @(negedge clk);
    frame_pulse(8);
    check_eq("fade8_level", 16'(fade_level), 16'd8);
    check_eq("fade8_busy", 16'(fade_busy), 16'd1);
    run_px("fade8", 10'd0, 10'd0, 12'hF84, 12'h742, 1'b0);

    // Reversal at level 5
    frame_pulse(3);
    check_eq("lvl5", 16'(fade_level), 16'd5);
    dark_en = 1'b0;
    @(negedge clk);
    check_eq("rev_busy", 16'(fade_busy), 16'd1);
    check_eq("rev_level_kept", 16'(fade_level), 16'd5);
    frame_pulse(1);
    check_eq("rev_lvl6", 16'(fade_level), 16'd6);
    frame_pulse(10);
    check_eq("rev_lvl16", 16'(fade_level), 16'd16);
    check_eq("rev_lit_busy", 16'(fade_busy), 16'd0);
    frame_pulse(1);
    check_eq("sat_top", 16'(fade_level), 16'd16);

    // Full dark, then the strict radius edge
    dark_en = 1'b1;
    @(negedge clk);
    frame_pulse(16);
    check_eq("dark_level", 16'(fade_level), 16'd0);
    check_eq("dark_busy", 16'(fade_busy), 16'd0);
    frame_pulse(1);
    check_eq("sat_bottom", 16'(fade_level), 16'd0);
    run_px("centre", 10'd200, 10'd200, 12'h5A3, 12'h5A3, 1'b1);
    run_px("edge400", 10'd240, 10'd200, 12'h5A3, 12'h000, 1'b0);
    run_px("in361", 10'd238, 10'd200, 12'h5A3, 12'h5A3, 1'b1);

    // Region boundary and per-light enable
    region_x0 = 9'd60;
    run_px("reg_x59", 10'd118, 10'd400, 12'h3C7, 12'h3C7, 1'b0);
    run_px("reg_x60", 10'd120, 10'd400, 12'h3C7, 12'h000, 1'b0);
    run_px("l1_off", 10'd400, 10'd400, 12'h3C7, 12'h000, 1'b0);
    light_en = 2'b11;
    run_px("l1_on", 10'd400, 10'd400, 12'h3C7, 12'h3C7, 1'b1);

    // Reset mid-fade with a valid pixel in the output register
    dark_en = 1'b0;
    @(negedge clk);
    frame_pulse(3);
    check_eq("lvl3", 16'(fade_level), 16'd3);
    run_px("pre_rst", 10'd200, 10'd200, 12'h9E1, 12'h9E1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_level", 16'(fade_level), 16'd16);
    check_eq("arst_valid", 16'(rgb_valid), 16'd0);
    check_eq("arst_rgb", 16'(rgb_out), 16'd0);
    dark_en = 1'b1;
    @(negedge clk) rst = 1'b0;
    frame_pulse(1);
    check_eq("post_rst_lvl15", 16'(fade_level), 16'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
